mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Memory stage of the RV32 pipeline, directly downstream of ALU_Top.
- Consumes the ALU result (effective address or pass-through value) and rs2 store data, and drives a req/gnt/rvalid data-memory bus.
- Performs byte-lane alignment plus load sign/zero extension, and stalls the pipeline while an access is outstanding.
- Presents a registered write-back bundle to the WB stage.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles waited for gnt or rvalid; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid_in  in  1  EX bundle valid.
- alu_result_in  in  32  ALU_Top result: address for load/store, data otherwise.
- store_data_in  in  32  rs2 value for stores.
- mem_read_in  in  1  load instruction.
- mem_write_in  in  1  store instruction.
- funct3_in  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rd_addr_in  in  5  destination register.
- reg_write_in  in  1  instruction writes rd.
- stall_out  out  1  upstream must hold its EX bundle.
- dmem_req_out  out  1  bus request.
- dmem_we_out  out  1  1 = write.
- dmem_addr_out  out  32  word-aligned address, bits [1:0] = 0.
- dmem_be_out  out  4  byte enables.
- dmem_wdata_out  out  32  lane-replicated store data.
- dmem_gnt_in  in  1  request accepted this cycle.
- dmem_rvalid_in  in  1  read data valid.
- dmem_rdata_in  in  32  read data.
- wb_valid_out  out  1  write-back bundle valid, one-cycle pulse.
- wb_data_out  out  32  result to rd.
- wb_rd_addr_out  out  5  destination register.
- wb_reg_write_out  out  1  rd write enable.
- mem_fault_out  out  1  one-cycle pulse on a misaligned or illegal access.

Behaviour:
- Reset values:
  - All outputs are 0; state is IDLE.
- FSM:
  - States: IDLE, REQ, WAIT_RD.
  - stall_out = (state != IDLE), combinational.
- Accept condition:
  - An EX bundle is accepted when ex_valid_in = 1 and state = IDLE.
  - Address, size, data, rd and reg_write are latched on acceptance.
- Non-memory op (mem_read_in = 0, mem_write_in = 0):
  - Next cycle: wb_valid_out = 1, wb_data_out = alu_result_in, and rd and reg_write are passed through.
  - Latency is 1 cycle; no stall.
- Fault check at acceptance:
  - Fault conditions:
    - H/HU access with addr[0] = 1.
    - W access with addr[1:0] != 0.
    - funct3 011/110/111.
    - funct3 1xx on a store.
    - mem_read_in and mem_write_in both set.
  - On a fault: no bus request is issued. Next cycle mem_fault_out = 1 and wb_valid_out = 1 with wb_reg_write_out = 0.
- Legal access:
  - Next state is REQ, with dmem_req_out = 1 registered.
  - dmem_addr_out = {addr[31:2], 2'b00}.
- Byte enables:
  - B: 0001 << addr[1:0].
  - H: 0011 << addr[1:0].
  - W: 1111.
  - Loads drive the same enables.
- Store data:
  - B: byte replicated to 4 lanes.
  - H: halfword replicated to 2 lanes.
  - W: as-is.
- REQ state:
  - dmem_req_out, dmem_we_out, addr, be and wdata are held stable until dmem_gnt_in = 1.
  - When gnt is sampled, dmem_req_out drops on the next edge.
  - Store: on gnt, go to IDLE. Next cycle wb_valid_out = 1 with wb_reg_write_out = 0.
  - Load: on gnt, go to WAIT_RD.
- WAIT_RD state:
  - dmem_rvalid_in is sampled only in this state. The bus guarantees rvalid arrives no earlier than the cycle after gnt.
  - On rvalid, go to IDLE. Next cycle wb_valid_out = 1 with the extracted data.
- Load data extraction:
  - Lane is selected by addr[1:0].
  - B/H are sign-extended; BU/HU are zero-extended.
- Back-to-back operation:
  - A new bundle can be accepted in the same cycle the FSM returns to IDLE, i.e. the cycle stall_out deasserts.
- Reset mid-operation:
  - State returns to IDLE and req drops at that edge; no wb_valid_out is produced.
  - A stray rvalid in IDLE or REQ is ignored.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter (wide enough for TIMEOUT_CYCLES) clears on entry to REQ or WAIT_RD and increments each cycle spent there.
  - When it reaches TIMEOUT_CYCLES, the access is aborted:
    - req drops and state goes to IDLE.
    - Next cycle mem_fault_out = 1 and wb_valid_out = 1 with wb_reg_write_out = 0.
- Not defined:
  - No counter is built; the block waits indefinitely for gnt or rvalid.

Test Plan:
- Non-mem: alu_result_in = 0x0000001E, rd = 5, reg_write = 1 → next cycle wb_valid = 1, wb_data = 0x1E, rd = 5, stall never asserted.
- LB from addr 0x1003, gnt at cycle 2, rvalid at cycle 4 with rdata = 0x80FFFFFF:
  - Expect be = 0001<<3 = 1000, dmem_addr_out = 0x1000.
  - wb_data = 0xFFFFFF80.
  - stall_out high from cycle 1 through the rvalid cycle.
- LHU from addr 0x2002 with rdata = 0x8001FFFF → be = 1100, wb_data = 0x00008001.
- SB to addr 0x3001, store_data = 0x12345678, gnt held low 3 cycles:
  - req/addr/be/wdata stay stable: addr 0x3000, be = 0010, wdata = 0x78787878.
  - After gnt, wb_valid = 1 with wb_reg_write = 0.
- LW to addr 0x4002 → no dmem_req_out; mem_fault_out = 1 for one cycle; wb_reg_write = 0.
- rst asserted while in WAIT_RD → next cycle all outputs are 0 and state is IDLE. A later rvalid produces no wb_valid.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, gnt never asserted → mem_fault_out pulses and stall_out deasserts.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - RV32 memory stage: dmem req/gnt/rvalid bus, lane alignment, registered WB bundle
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [4:0]  rd_addr_in,
    input  logic        reg_write_in,
    output logic        stall_out,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [3:0]  dmem_be_out,
    output logic [31:0] dmem_wdata_out,
    input  logic        dmem_gnt_in,
    input  logic        dmem_rvalid_in,
    input  logic [31:0] dmem_rdata_in,
    output logic        wb_valid_out,
    output logic [31:0] wb_data_out,
    output logic [4:0]  wb_rd_addr_out,
    output logic        wb_reg_write_out,
    output logic        mem_fault_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        rw_q;
    logic        accept;
    logic        is_mem;
    logic        fault;
    logic        timeout_hit;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] rd_shifted;
    logic [31:0] load_data;

    assign accept    = ex_valid_in && (state == IDLE);
    assign is_mem    = mem_read_in || mem_write_in;
    assign stall_out = (state != IDLE);

    always_comb begin
        fault = 1'b0;
        case (funct3_in)
            3'b000, 3'b100: fault = 1'b0;
            3'b001, 3'b101: fault = alu_result_in[0];
            3'b010:         fault = |alu_result_in[1:0];
            default:        fault = 1'b1;
        endcase
        if (funct3_in[2] && mem_write_in)
            fault = 1'b1;
        if (mem_read_in && mem_write_in)
            fault = 1'b1;
    end

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = store_data_in;
        case (funct3_in[1:0])
            2'b00: begin
                be_next    = 4'b0001 << alu_result_in[1:0];
                wdata_next = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << alu_result_in[1:0];
                wdata_next = {2{store_data_in[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = store_data_in;
            end
        endcase
    end

    assign rd_shifted = dmem_rdata_in >> {off_q, 3'b000};

    always_comb begin
        load_data = dmem_rdata_in;
        case (f3_q)
            3'b000:  load_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b001:  load_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b100:  load_data = {24'd0, rd_shifted[7:0]};
            3'b101:  load_data = {16'd0, rd_shifted[15:0]};
            default: load_data = dmem_rdata_in;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst || state == IDLE || state_next != state)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end

    assign timeout_hit = (state != IDLE) && (to_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && is_mem && !fault)
                    state_next = REQ;
            end
            REQ: begin
                if (dmem_gnt_in)
                    state_next = dmem_we_out ? IDLE : WAIT_RD;
                else if (timeout_hit)
                    state_next = IDLE;
            end
            WAIT_RD: begin
                if (dmem_rvalid_in || timeout_hit)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req_out     <= 1'b0;
            dmem_we_out      <= 1'b0;
            dmem_addr_out    <= '0;
            dmem_be_out      <= '0;
            dmem_wdata_out   <= '0;
            wb_valid_out     <= 1'b0;
            wb_data_out      <= '0;
            wb_rd_addr_out   <= '0;
            wb_reg_write_out <= 1'b0;
            mem_fault_out    <= 1'b0;
            f3_q             <= '0;
            off_q            <= '0;
            rw_q             <= 1'b0;
        end else begin
            wb_valid_out  <= 1'b0;
            mem_fault_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        wb_rd_addr_out <= rd_addr_in;
                        f3_q           <= funct3_in;
                        off_q          <= alu_result_in[1:0];
                        rw_q           <= reg_write_in;
                        if (!is_mem) begin
                            wb_valid_out     <= 1'b1;
                            wb_data_out      <= alu_result_in;
                            wb_reg_write_out <= reg_write_in;
                        end else if (fault) begin
                            wb_valid_out     <= 1'b1;
                            wb_data_out      <= '0;
                            wb_reg_write_out <= 1'b0;
                            mem_fault_out    <= 1'b1;
                        end else begin
                            dmem_req_out   <= 1'b1;
                            dmem_we_out    <= mem_write_in;
                            dmem_addr_out  <= {alu_result_in[31:2], 2'b00};
                            dmem_be_out    <= be_next;
                            dmem_wdata_out <= wdata_next;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt_in) begin
                        dmem_req_out <= 1'b0;
                        if (dmem_we_out) begin
                            wb_valid_out     <= 1'b1;
                            wb_reg_write_out <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        dmem_req_out     <= 1'b0;
                        wb_valid_out     <= 1'b1;
                        wb_reg_write_out <= 1'b0;
                        mem_fault_out    <= 1'b1;
                    end
                end
                WAIT_RD: begin
                    if (dmem_rvalid_in) begin
                        wb_valid_out     <= 1'b1;
                        wb_data_out      <= load_data;
                        wb_reg_write_out <= rw_q;
                    end else if (timeout_hit) begin
                        wb_valid_out     <= 1'b1;
                        wb_reg_write_out <= 1'b0;
                        mem_fault_out    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed plus randomized check of mem_stage_lsu against a behavioural model
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_in;
    logic [31:0] alu_result_in;
    logic [31:0] store_data_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [2:0]  funct3_in;
    logic [4:0]  rd_addr_in;
    logic        reg_write_in;
    logic        stall_out;
    logic        dmem_req_out;
    logic        dmem_we_out;
    logic [31:0] dmem_addr_out;
    logic [3:0]  dmem_be_out;
    logic [31:0] dmem_wdata_out;
    logic        dmem_gnt_in;
    logic        dmem_rvalid_in;
    logic [31:0] dmem_rdata_in;
    logic        wb_valid_out;
    logic [31:0] wb_data_out;
    logic [4:0]  wb_rd_addr_out;
    logic        wb_reg_write_out;
    logic        mem_fault_out;

    int total = 0;
    int bad   = 0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid_in      (ex_valid_in),
        .alu_result_in    (alu_result_in),
        .store_data_in    (store_data_in),
        .mem_read_in      (mem_read_in),
        .mem_write_in     (mem_write_in),
        .funct3_in        (funct3_in),
        .rd_addr_in       (rd_addr_in),
        .reg_write_in     (reg_write_in),
        .stall_out        (stall_out),
        .dmem_req_out     (dmem_req_out),
        .dmem_we_out      (dmem_we_out),
        .dmem_addr_out    (dmem_addr_out),
        .dmem_be_out      (dmem_be_out),
        .dmem_wdata_out   (dmem_wdata_out),
        .dmem_gnt_in      (dmem_gnt_in),
        .dmem_rvalid_in   (dmem_rvalid_in),
        .dmem_rdata_in    (dmem_rdata_in),
        .wb_valid_out     (wb_valid_out),
        .wb_data_out      (wb_data_out),
        .wb_rd_addr_out   (wb_rd_addr_out),
        .wb_reg_write_out (wb_reg_write_out),
        .mem_fault_out    (mem_fault_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        logic [110:0] v;
        v = {stall_out, dmem_req_out, dmem_we_out, dmem_addr_out, dmem_be_out, dmem_wdata_out,
             wb_valid_out, wb_data_out, wb_rd_addr_out, wb_reg_write_out, mem_fault_out};
        total++;
        assert (v === '0) else begin
            bad++;
            $error("FAIL %s observed=%h expected=0", tag, v);
        end
    endtask

    function automatic int acc_bytes(input logic [2:0] f3);
        if (f3 % 4 == 0) return 1;
        if (f3 % 4 == 1) return 2;
        return 4;
    endfunction

    function automatic bit m_fault(input bit rdo, input bit wro, input logic [2:0] f3, input logic [31:0] a);
        if (rdo && wro) return 1;
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1;
        if (wro && f3 >= 4) return 1;
        if (a % acc_bytes(f3) != 0) return 1;
        return 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = acc_bytes(f3);
        if (n == 4) return 4'hF;
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        int n;
        n = acc_bytes(f3);
        if (n == 1) return (d & 32'hFF) * 32'h01010101;
        if (n == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
        int          bits;
        logic [31:0] v;
        bits = 8 * acc_bytes(f3);
        if (bits == 32) return rdata;
        v = (rdata >> (8 * (a % 4))) & ((32'd1 << bits) - 1);
        if (f3 < 4 && v >= (32'd1 << (bits - 1)))
            v = v - (32'd1 << bits);
        return v;
    endfunction

    task automatic access(input bit rdo, input bit wro, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] rd, input bit rw,
                          input int gd, input int rvd, input logic [31:0] rdata);
        chk("stall_before_accept", 32'(stall_out), 32'd0);
        ex_valid_in   = 1'b1;
        alu_result_in = a;
        store_data_in = sd;
        mem_read_in   = rdo;
        mem_write_in  = wro;
        funct3_in     = f3;
        rd_addr_in    = rd;
        reg_write_in  = rw;
        tick();
        ex_valid_in   = 1'b0;
        mem_read_in   = 1'b0;
        mem_write_in  = 1'b0;
        alu_result_in = $urandom;
        store_data_in = $urandom;
        funct3_in     = 3'($urandom);
        if (!rdo && !wro) begin
            chk("nm_wb_valid", 32'(wb_valid_out), 32'd1);
            chk("nm_wb_data", wb_data_out, a);
            chk("nm_wb_rd", 32'(wb_rd_addr_out), 32'(rd));
            chk("nm_wb_rw", 32'(wb_reg_write_out), 32'(rw));
            chk("nm_stall", 32'(stall_out), 32'd0);
            chk("nm_req", 32'(dmem_req_out), 32'd0);
        end else if (m_fault(rdo, wro, f3, a)) begin
            chk("flt_req", 32'(dmem_req_out), 32'd0);
            chk("flt_fault", 32'(mem_fault_out), 32'd1);
            chk("flt_wb_valid", 32'(wb_valid_out), 32'd1);
            chk("flt_wb_rw", 32'(wb_reg_write_out), 32'd0);
            chk("flt_stall", 32'(stall_out), 32'd0);
            tick();
            chk("flt_pulse_end", 32'({mem_fault_out, wb_valid_out, dmem_req_out}), 32'd0);
        end else begin
            for (int i = 0; i <= gd; i++) begin
                chk("req_hold", 32'(dmem_req_out), 32'd1);
                chk("req_stall", 32'(stall_out), 32'd1);
                chk("req_addr", dmem_addr_out, a - (a % 4));
                chk("req_be", 32'(dmem_be_out), 32'(m_be(f3, a)));
                chk("req_we", 32'(dmem_we_out), 32'(wro));
                if (wro) chk("req_wdata", dmem_wdata_out, m_wdata(f3, sd));
                chk("req_no_wb", 32'(wb_valid_out), 32'd0);
                dmem_rvalid_in = 1'($urandom);
                dmem_rdata_in  = $urandom;
                if (i == gd) dmem_gnt_in = 1'b1;
                tick();
            end
            dmem_gnt_in    = 1'b0;
            dmem_rvalid_in = 1'b0;
            chk("req_dropped", 32'(dmem_req_out), 32'd0);
            if (wro) begin
                chk("st_wb_valid", 32'(wb_valid_out), 32'd1);
                chk("st_wb_rw", 32'(wb_reg_write_out), 32'd0);
                chk("st_stall", 32'(stall_out), 32'd0);
            end else begin
                chk("ld_wait_stall", 32'(stall_out), 32'd1);
                chk("ld_wait_no_wb", 32'(wb_valid_out), 32'd0);
                for (int i = 0; i < rvd; i++) begin
                    tick();
                    chk("ld_wait_stall", 32'(stall_out), 32'd1);
                end
                dmem_rvalid_in = 1'b1;
                dmem_rdata_in  = rdata;
                tick();
                dmem_rvalid_in = 1'b0;
                dmem_rdata_in  = $urandom;
                chk("ld_wb_valid", 32'(wb_valid_out), 32'd1);
                chk("ld_wb_data", wb_data_out, m_load(f3, a, rdata));
                chk("ld_wb_rd", 32'(wb_rd_addr_out), 32'(rd));
                chk("ld_wb_rw", 32'(wb_reg_write_out), 32'(rw));
                chk("ld_stall", 32'(stall_out), 32'd0);
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        int          kind;
        bit          seen;

        rst            = 1'b1;
        ex_valid_in    = 1'b0;
        alu_result_in  = '0;
        store_data_in  = '0;
        mem_read_in    = 1'b0;
        mem_write_in   = 1'b0;
        funct3_in      = '0;
        rd_addr_in     = '0;
        reg_write_in   = 1'b0;
        dmem_gnt_in    = 1'b0;
        dmem_rvalid_in = 1'b0;
        dmem_rdata_in  = '0;
        tick();
        tick();
        chk_all_zero("reset_outputs");
        rst = 1'b0;
        tick();

        access(0, 0, 3'b000, 32'h0000001E, 32'h0, 5'd5, 1, 0, 0, 32'h0);
        access(1, 0, 3'b000, 32'h00001003, 32'h0, 5'd7, 1, 1, 1, 32'h80FFFFFF);
        access(1, 0, 3'b101, 32'h00002002, 32'h0, 5'd8, 1, 0, 0, 32'h8001FFFF);
        access(0, 1, 3'b000, 32'h00003001, 32'h12345678, 5'd9, 0, 3, 0, 32'h0);
        access(1, 0, 3'b010, 32'h00004002, 32'h0, 5'd10, 1, 0, 0, 32'h0);
        access(1, 0, 3'b001, 32'h00005006, 32'h0, 5'd11, 1, 2, 3, 32'h00008234);
        access(0, 1, 3'b001, 32'h00006002, 32'hCAFEBEEF, 5'd12, 0, 0, 0, 32'h0);

        ex_valid_in   = 1'b1;
        alu_result_in = 32'h00007000;
        mem_read_in   = 1'b1;
        funct3_in     = 3'b010;
        rd_addr_in    = 5'd3;
        reg_write_in  = 1'b1;
        tick();
        ex_valid_in   = 1'b0;
        mem_read_in   = 1'b0;
        dmem_gnt_in   = 1'b1;
        tick();
        dmem_gnt_in   = 1'b0;
        chk("pre_rst_wait_stall", 32'(stall_out), 32'd1);
        rst = 1'b1;
        tick();
        chk_all_zero("rst_in_wait_rd");
        rst = 1'b0;
        dmem_rvalid_in = 1'b1;
        dmem_rdata_in  = 32'hDEADBEEF;
        tick();
        dmem_rvalid_in = 1'b0;
        chk("stray_rvalid_no_wb", 32'({wb_valid_out, stall_out}), 32'd0);

        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 4));
            f3   = 3'($urandom);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0 && f3 != 3 && f3 < 6)
                a = a - (a % acc_bytes(f3));
            if (kind == 2 && $urandom_range(0, 3) != 0)
                f3 = 3'($urandom_range(0, 2));
            access(kind == 1 || kind == 3 || kind == 4, kind == 2 || kind == 4, f3, a,
                   $urandom, 5'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
        end

`ifdef MEM_TIMEOUT_EN
        ex_valid_in   = 1'b1;
        alu_result_in = 32'h00008000;
        mem_read_in   = 1'b1;
        funct3_in     = 3'b010;
        tick();
        ex_valid_in   = 1'b0;
        mem_read_in   = 1'b0;
        seen          = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (mem_fault_out) seen = 1'b1;
        end
        chk("timeout_fault_seen", 32'(seen), 32'd1);
        chk("timeout_stall", 32'(stall_out), 32'd0);
        chk("timeout_wb_rw", 32'(wb_reg_write_out), 32'd0);
        chk("timeout_req", 32'(dmem_req_out), 32'd0);
`else
        seen = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
